// File: rtl/mmcm_drp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_drp_ctrl
//  Description : Reconfigures the AES-GCM core-clock MMCM through its DRP.
//                The MMCM is held in reset while every table entry gets a
//                read-modify-write. Reset is then released, LOCKED is awaited,
//                and done/error is reported.
//                Optional readback check of each write: define DRP_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmcm_drp_ctrl #(
    parameter int NUM_ENTRIES  = 23,
    parameter int IDX_W        = 5,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RST_HOLD     = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_req,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_err,
    output logic [IDX_W-1:0] o_tbl_idx,
    input  logic [6:0]       i_tbl_addr,
    input  logic [15:0]      i_tbl_mask,
    input  logic [15:0]      i_tbl_data,
    output logic [6:0]       o_daddr,
    output logic [15:0]      o_di,
    output logic             o_den,
    output logic             o_dwe,
    input  logic [15:0]      i_do,
    input  logic             i_drdy,
    output logic             o_mmcm_rst,
    input  logic             i_mmcm_locked,
    output logic             o_locked
);

    // One shared counter serves the reset hold, DRDY and lock timeouts
    localparam int c_MAX_A   = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int c_MAX_CNT = (c_MAX_A > RST_HOLD) ? c_MAX_A : RST_HOLD;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(RST_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_DRDY_LAST = c_CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   c_IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]   c_IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);

    localparam logic [1:0] c_ERR_NONE = 2'd0;
    localparam logic [1:0] c_ERR_DRDY = 2'd1;
    localparam logic [1:0] c_ERR_LOCK = 2'd2;
`ifdef DRP_READBACK_EN
    localparam logic [1:0] c_ERR_RB   = 2'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD,
        S_RD,
        S_WAIT_RD,
        S_WR,
        S_WAIT_WR,
`ifdef DRP_READBACK_EN
        S_RB,
        S_WAIT_RB,
`endif
        S_NEXT,
        S_REL,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 mrst_q, mrst_d;
    logic [6:0]           daddr_q, daddr_d;
    logic [15:0]          di_q, di_d;
    logic                 w_den;
    logic                 w_dwe;

    // State and datapath registers; reset aborts any sequence and drops MMCM RST
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= c_ERR_NONE;
            busy_q  <= 1'b0;
            mrst_q  <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            mrst_q  <= mrst_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
        end
    end

    // Sequencer: next state, counters, sticky first error and DRP strobes
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        mrst_d  = mrst_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        w_den   = 1'b0;
        w_dwe   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    err_d   = c_ERR_NONE;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    mrst_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == c_HOLD_LAST) state_d = S_RD;
                else                      cnt_d   = cnt_q + c_CNT_ONE;
            end
            S_RD: begin
                w_den   = 1'b1;
                daddr_d = i_tbl_addr;
                cnt_d   = '0;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                // Expiry wins over a DRDY landing in the same cycle
                if (cnt_q == c_DRDY_LAST) begin
                    if (err_q == c_ERR_NONE) err_d = c_ERR_DRDY;
                    state_d = S_REL;
                end else if (i_drdy) begin
                    di_d    = (i_do & i_tbl_mask) | (i_tbl_data & ~i_tbl_mask);
                    state_d = S_WR;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            S_WR: begin
                w_den   = 1'b1;
                w_dwe   = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (cnt_q == c_DRDY_LAST) begin
                    if (err_q == c_ERR_NONE) err_d = c_ERR_DRDY;
                    state_d = S_REL;
                end else if (i_drdy) begin
`ifdef DRP_READBACK_EN
                    state_d = S_RB;
`else
                    state_d = S_NEXT;
`endif
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
`ifdef DRP_READBACK_EN
            S_RB: begin
                w_den   = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_RB;
            end
            S_WAIT_RB: begin
                if (cnt_q == c_DRDY_LAST) begin
                    if (err_q == c_ERR_NONE) err_d = c_ERR_DRDY;
                    state_d = S_REL;
                end else if (i_drdy) begin
                    // Only the bits this entry owns are expected to match
                    if (((i_do ^ i_tbl_data) & ~i_tbl_mask) != 16'd0) begin
                        if (err_q == c_ERR_NONE) err_d = c_ERR_RB;
                        state_d = S_REL;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
`endif
            S_NEXT: begin
                if (idx_q == c_IDX_LAST) begin
                    state_d = S_REL;
                end else begin
                    idx_d   = idx_q + c_IDX_ONE;
                    state_d = S_RD;
                end
            end
            S_REL: begin
                mrst_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (cnt_q == c_LOCK_LAST) begin
                    if (err_q == c_ERR_NONE) err_d = c_ERR_LOCK;
                    state_d = S_DONE;
                end else if (i_mmcm_locked) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address comes straight from the ROM during RD so it is valid with DEN
    assign o_daddr    = (state_q == S_RD) ? i_tbl_addr : daddr_q;
    assign o_di       = di_q;
    assign o_den      = w_den;
    assign o_dwe      = w_dwe;
    assign o_busy     = busy_q;
    assign o_done     = (state_q == S_DONE);
    assign o_err      = err_q;
    assign o_tbl_idx  = idx_q;
    assign o_mmcm_rst = mrst_q;
    // LOCKED is only meaningful to downstream logic once the sequence is idle
    assign o_locked   = i_reset_n & (state_q == S_IDLE) & i_mmcm_locked;

endmodule
`default_nettype wire

// File: doc/mmcm_drp_ctrl.md
Name: mmcm_drp_ctrl

Overview:
- Sequences run-time reconfiguration of the AES-GCM core-clock MMCM through its Dynamic Reconfiguration Port (DRP).
- On request, holds the MMCM in reset and performs a read-modify-write of every table entry (address, keep-mask, data). It then releases reset, waits for LOCKED and reports done or error.
- Sits beside the clock generator. DCLK is tied to i_clk externally. The register table is an external ROM indexed by o_tbl_idx.

Parameters:
- NUM_ENTRIES, 23, DRP table entries per reconfiguration (1..2^IDX_W).
- IDX_W, 5, width of o_tbl_idx.
- DRDY_TIMEOUT, 64, max cycles from DEN to DRDY before error.
- LOCK_TIMEOUT, 65536, max cycles from reset release to LOCKED before error.
- RST_HOLD, 4, cycles o_mmcm_rst is held before the first DRP access.

Ports:
- i_clk  in  1  system clock, also the DRP DCLK
- i_reset_n  in  1  asynchronous active-low reset
- i_req  in  1  start reconfiguration; sampled in IDLE only
- o_busy  out  1  high from the request-accept cycle until the DONE state exits
- o_done  out  1  one-cycle pulse at end of sequence
- o_err  out  2  0 none, 1 DRDY timeout, 2 lock timeout, 3 readback mismatch; valid with o_done, held until next accept
- o_tbl_idx  out  IDX_W  current table index
- i_tbl_addr  in  7  DRP address of entry o_tbl_idx (combinational ROM)
- i_tbl_mask  in  16  bits set = keep existing value
- i_tbl_data  in  16  new bit values
- o_daddr  out  7  DRP address
- o_di  out  16  DRP write data
- o_den  out  1  DRP enable, one-cycle pulse
- o_dwe  out  1  DRP write enable, only with o_den
- i_do  in  16  DRP read data
- i_drdy  in  1  DRP ready
- o_mmcm_rst  out  1  MMCM RST
- i_mmcm_locked  in  1  MMCM LOCKED (from the MMCM, same clock domain after external sync)
- o_locked  out  1  i_mmcm_locked gated: forced 0 unless the state is IDLE

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; all outputs 0; o_tbl_idx=0; counters cleared. Reset during any state aborts immediately and drops o_mmcm_rst. No partial-sequence recovery; the MMCM relocks on whatever config it holds.
- IDLE: if i_req=1, clear o_err, set o_busy, set idx=0 and go to HOLD.
- HOLD: o_mmcm_rst=1; count RST_HOLD cycles, then go to RD.
- RD (1 cycle): o_daddr<=i_tbl_addr, o_den=1, o_dwe=0; go to WAIT_RD.
- WAIT_RD: on i_drdy, capture new=(i_do & i_tbl_mask)|(i_tbl_data & ~i_tbl_mask) and go to WR.
- WR (1 cycle): o_den=1, o_dwe=1, o_di=new, o_daddr unchanged; go to WAIT_WR.
- WAIT_WR: on i_drdy, go to NEXT.
- NEXT: if idx==NUM_ENTRIES-1, go to REL; else idx++ and go to RD.
- REL: o_mmcm_rst<=0 and clear the lock counter; go to WAIT_LOCK.
- WAIT_LOCK: when i_mmcm_locked=1, go to DONE.
- DONE: o_done=1 for one cycle; o_busy falls the next cycle and the state returns to IDLE.
- Timeouts:
  - Each WAIT_RD/WAIT_WR counts from 0. Reaching DRDY_TIMEOUT gives o_err=1 and the sequence goes to REL; REL is always executed so the MMCM is never left in reset.
  - Reaching LOCK_TIMEOUT in WAIT_LOCK gives o_err=2 and goes to DONE.
- Timeout has priority over a DRDY arriving in the same cycle as expiry. The first error is sticky and later errors do not overwrite it.
- A DRDY seen outside the WAIT states is ignored.
- i_req while busy is ignored; there is no queueing.
- Per-entry cost with immediate DRDY (arriving the cycle after DEN): RD(1)+WAIT_RD(1)+WR(1)+WAIT_WR(1)+NEXT(1) = 5 cycles. Total = 1 + RST_HOLD + 5*NUM_ENTRIES + 1 + lock wait + 1.
- o_den is never asserted in two consecutive cycles, and never while the state is outside RD/WR (or RB with the optional feature).

Optional Feature:
- Macro: DRP_READBACK_EN.
- Defined: after WAIT_WR, a readback is added:
  - RB (1 cycle): o_den=1, o_dwe=0.
  - WAIT_RB: on i_drdy, compare (i_do & ~i_tbl_mask) with (i_tbl_data & ~i_tbl_mask). A mismatch sets o_err=3 and goes to REL; a match goes to NEXT.
  - Per-entry cost becomes 7 cycles.
- Undefined: no RB states exist and o_err never equals 3.

Test Plan:
- NUM_ENTRIES=2, DRP model with 1-cycle DRDY, reg 0x08 holds 0xFFFF, entry {0x08, mask 0x1000, data 0x0041} → write o_di=0x1041. o_mmcm_rst high from HOLD to REL. Locked after 100 cycles → o_done pulse, o_err=0.
- DRP model never asserts DRDY on entry 1 → o_err=1 after 64 cycles, o_mmcm_rst released, o_done pulses, no further DEN.
- i_mmcm_locked held 0 after REL → o_err=2 exactly LOCK_TIMEOUT cycles after REL. o_locked stays 0 throughout and returns to following i_mmcm_locked in IDLE.
- i_req pulsed again mid-sequence, then i_reset_n pulsed low during WAIT_WR → pulsed request has no effect. Reset forces all outputs 0 immediately, and a new request then restarts at idx=0.
- DRDY returned in the same cycle as the DEN+1 timeout boundary (DRDY_TIMEOUT=1) → o_err=1 (timeout wins).
- With DRP_READBACK_EN: model corrupts bit 0 on write → o_err=3 at the first entry, REL executed, o_done pulses.
